// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared state encoding, counter widths and parameter range check for mem_arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_e;
  localparam int STARVE_W = 4;
  localparam int LAT_W = 2;
  function automatic bit params_ok(input int mem_lat, input int starve_max);
    return mem_lat >= 1 && mem_lat <= 4 && starve_max >= 1 && starve_max <= 15;
  endfunction
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter between fetch (I) and data (D) sides, one outstanding access
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [DATA_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [3:0]        d_be_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [3:0]        m_be_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_wdata_o,
  input  logic [DATA_W-1:0] m_rdata_i,
  output logic              busy_o
);
  if (!params_ok(MEM_LAT, STARVE_MAX)) begin : g_bad_params
    $error("mem_arbiter: MEM_LAT must be 1..4 and STARVE_MAX 1..15");
  end
  state_e              state_q;
  logic [LAT_W-1:0]    lat_q;
  logic [STARVE_W-1:0] starve_q;
  logic                sel_i_q;
  logic                i_gnt_q, d_gnt_q, i_rvalid_q, d_rvalid_q, m_req_q, m_we_q, busy_q;
  logic [3:0]          m_be_q;
  logic [ADDR_W-1:0]   m_addr_q;
  logic [DATA_W-1:0]   m_wdata_q, i_rdata_q, d_rdata_q;
  logic                i_win_d;
  logic                starved_d;
  // D wins ties unless I has waited through STARVE_MAX consecutive D grants
  always_comb begin
    starved_d = starve_q == STARVE_W'(STARVE_MAX);
    i_win_d   = i_req_i && (!d_req_i || starved_d);
  end
  // grant FSM with latency counter, starvation counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      starve_q   <= '0;
      sel_i_q    <= 1'b0;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      m_req_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      case (state_q)
        S_IDLE: begin
          starve_q <= (!i_req_i || i_win_d) ? '0 : starve_q + STARVE_W'(!starved_d);
          if (i_req_i || d_req_i) begin
            state_q   <= S_GRANT;
            busy_q    <= 1'b1;
            sel_i_q   <= i_win_d;
            i_gnt_q   <= i_win_d;
            d_gnt_q   <= !i_win_d;
            m_req_q   <= 1'b1;
            m_we_q    <= !i_win_d && d_we_i;
            m_be_q    <= i_win_d ? 4'hF : d_be_i;
            m_addr_q  <= i_win_d ? i_addr_i : d_addr_i;
            m_wdata_q <= i_win_d ? '0 : d_wdata_i;
          end
        end
        S_GRANT: begin
          state_q <= S_WAIT;
          lat_q   <= LAT_W'(MEM_LAT - 1);
        end
        S_WAIT: begin
          lat_q <= lat_q - LAT_W'(1);
          if (lat_q == '0) begin
            state_q    <= S_RESP;
            busy_q     <= 1'b0;
            i_rvalid_q <= sel_i_q;
            d_rvalid_q <= !sel_i_q;
            i_rdata_q  <= sel_i_q ? m_rdata_i : '0;
            d_rdata_q  <= (!sel_i_q && !m_we_q) ? m_rdata_i : '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign i_gnt_o    = i_gnt_q;
  assign d_gnt_o    = d_gnt_q;
  assign i_rvalid_o = i_rvalid_q;
  assign d_rvalid_o = d_rvalid_q;
  assign i_rdata_o  = i_rdata_q;
  assign d_rdata_o  = d_rdata_q;
  assign m_req_o    = m_req_q;
  assign m_we_o     = m_we_q;
  assign m_be_o     = m_be_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;
  assign busy_o     = busy_q;
  a_i_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $past(i_req_i && !i_gnt_o) && !i_gnt_o |-> i_req_i);
  a_d_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $past(d_req_i && !d_gnt_o) && !d_gnt_o |-> d_req_i);
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of reset, fetch, tie, store, starvation and latency sweep
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        i_req, d_req, d_we, sw_req;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        sw_gnt [2:4];
  logic        sw_rv [2:4];
  logic [31:0] sw_rd [2:4];
  logic        sw_dg [2:4];
  logic        sw_drv [2:4];
  logic [31:0] sw_drd [2:4];
  logic        sw_mreq [2:4];
  logic        sw_mwe [2:4];
  logic [3:0]  sw_mbe [2:4];
  logic [31:0] sw_maddr [2:4];
  logic [31:0] sw_mwd [2:4];
  logic        sw_busy [2:4];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .m_req_o(m_req), .m_we_o(m_we), .m_be_o(m_be), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
    .m_rdata_i(m_rdata), .busy_o(busy)
  );

  for (genvar g = 2; g <= 4; g++) begin : g_sw
    mem_arbiter #(.MEM_LAT(g), .STARVE_MAX(4)) u_sw (
      .clk_i(clk), .rst_ni(rst_ni),
      .i_req_i(sw_req), .i_addr_i(i_addr), .i_gnt_o(sw_gnt[g]), .i_rvalid_o(sw_rv[g]), .i_rdata_o(sw_rd[g]),
      .d_req_i(1'b0), .d_we_i(1'b0), .d_be_i(4'h0), .d_addr_i(32'h0), .d_wdata_i(32'h0),
      .d_gnt_o(sw_dg[g]), .d_rvalid_o(sw_drv[g]), .d_rdata_o(sw_drd[g]),
      .m_req_o(sw_mreq[g]), .m_we_o(sw_mwe[g]), .m_be_o(sw_mbe[g]), .m_addr_o(sw_maddr[g]),
      .m_wdata_o(sw_mwd[g]), .m_rdata_i(32'hC0DE_0000 | 32'(g)), .busy_o(sw_busy[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    {i_req, d_req, d_we, sw_req} = '0;
    {i_addr, d_addr, d_wdata, m_rdata} = '0;
    d_be = 4'h0;
    repeat (3) tick();
    chk("rst_ctl", {i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_be, busy}, 64'h0);
    chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
    chk("rst_mem", {m_addr, m_wdata}, 64'h0);
    rst_ni = 1'b1;
    tick();
    i_req = 1'b1; i_addr = 32'h40; m_rdata = 32'h0000_0013;
    tick();
    chk("f_gnt", {i_gnt, d_gnt, m_req, m_we, busy}, 64'b10101);
    chk("f_addr", m_addr, 64'h40);
    chk("f_be", m_be, 64'hF);
    i_req = 1'b0;
    tick();
    chk("f_wait", {i_gnt, m_req, i_rvalid, busy}, 64'b0001);
    tick();
    chk("f_rv", {i_rvalid, d_rvalid, busy}, 64'b100);
    chk("f_rdata", i_rdata, 64'h13);
    tick();
    chk("f_rv_end", i_rvalid, 64'h0);
    i_req = 1'b1; i_addr = 32'h80;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0010_0100; m_rdata = 32'h1111_1111;
    tick();
    chk("tie_d_gnt", {i_gnt, d_gnt}, 64'b01);
    chk("tie_d_addr", m_addr, 64'h0010_0100);
    d_req = 1'b0;
    tick();
    tick();
    chk("tie_d_rv", {i_rvalid, d_rvalid}, 64'b01);
    chk("tie_d_rdata", d_rdata, 64'h1111_1111);
    tick();
    chk("tie_idle", {i_gnt, d_gnt, m_req}, 64'h0);
    tick();
    chk("tie_i_gnt", {i_gnt, d_gnt}, 64'b10);
    chk("tie_i_addr", m_addr, 64'h80);
    i_req = 1'b0;
    tick();
    tick();
    chk("tie_i_rv", {i_rvalid, i_rdata}, {31'h0, 1'b1, 32'h1111_1111});
    tick();
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h0010_0004;
    m_rdata = 32'hFFFF_FFFF;
    tick();
    chk("st_gnt", {d_gnt, m_req, m_we, m_be}, 64'b1110011);
    chk("st_addr", m_addr, 64'h0010_0004);
    chk("st_wdata", m_wdata, 64'hDEAD_BEEF);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    tick();
    chk("st_rv", {d_rvalid, d_rdata}, {31'h0, 1'b1, 32'h0});
    tick();
    chk("st_rv_end", d_rvalid, 64'h0);
    i_req = 1'b1; i_addr = 32'h200; d_req = 1'b1; d_be = 4'hF; d_addr = 32'h300;
    tick();
    chk("sv_g1_d", {i_gnt, d_gnt}, 64'b01);
    repeat (4) tick();
    chk("sv_g2_d", {i_gnt, d_gnt}, 64'b01);
    repeat (4) tick();
    chk("sv_g3_i", {i_gnt, d_gnt}, 64'b10);
    chk("sv_g3_addr", m_addr, 64'h200);
    i_req = 1'b0;
    tick();
    tick();
    chk("sv_i_rv", i_rvalid, 64'h1);
    i_req = 1'b1;
    tick();
    tick();
    chk("sv_g4_d", {i_gnt, d_gnt}, 64'b01);
    d_req = 1'b0;
    repeat (4) tick();
    chk("sv_g5_i", {i_gnt, d_gnt}, 64'b10);
    i_req = 1'b0;
    repeat (3) tick();
    d_req = 1'b1; d_addr = 32'h500;
    tick();
    chk("rw_gnt", d_gnt, 64'h1);
    tick();
    chk("rw_busy", busy, 64'h1);
    rst_ni = 1'b0; d_req = 1'b0;
    #2;
    chk("rw_ctl", {i_gnt, i_rvalid, d_gnt, d_rvalid, m_req, m_we, m_be, busy}, 64'h0);
    chk("rw_mem", {m_addr, m_wdata}, 64'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("rw_no_rv_%0d", k), {d_rvalid, i_rvalid}, 64'h0);
    end
    i_req = 1'b1; sw_req = 1'b1; i_addr = 32'h44; m_rdata = 32'h0000_600D;
    tick();
    chk("sw_gnt_L1", i_gnt, 64'h1);
    for (int l = 2; l <= 4; l++) chk($sformatf("sw_gnt_L%0d", l), sw_gnt[l], 64'h1);
    i_req = 1'b0; sw_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("sw_rv_L1_k%0d", k), {i_rvalid, i_rdata}, (k == 2) ? {31'h0, 1'b1, 32'h600D} : 64'h0);
      for (int l = 2; l <= 4; l++)
        chk($sformatf("sw_rv_L%0d_k%0d", l, k), {sw_rv[l], sw_rd[l]},
            (k == l + 1) ? {31'h0, 1'b1, 32'hC0DE_0000 | 32'(l)} : 64'h0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
